gnr_node_ecm: RTL and testbench

- Parametrised gene-regulatory-network node holding NUM_COPIES independent state copies (trajectories) of WIDTH-bit multi-valued state.
- Each copy advances on its own start strobe with a programmable update divider and a saturating activator/inhibitor rule; current states are exported to the ECM.
- Sits in the GNR simulation array, one instance per gene; the controller drives the strobes and reset_nos.

---
 rtl/gnr_pkg.sv | 47 ++++
 rtl/gnr_node_ecm_if.sv | 27 ++
 rtl/gnr_node_lane.sv | 106 ++++++++++
 rtl/gnr_node_ecm.sv | 44 ++++
 tb/tb_gnr_node_ecm.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/gnr_pkg.sv
// Shared types and helpers for the gene-regulatory-network node: regulation score,
// saturating state step and width derivations.
package gnr_pkg;

    typedef enum logic [1:0] {
        DIR_HOLD = 2'd0,
        DIR_UP   = 2'd1,
        DIR_DOWN = 2'd2
    } dir_e;

    // Signed score must hold -NUM_IN..+NUM_IN
    function automatic int score_w(input int n_in);
        return $clog2(n_in + 1) + 1;
    endfunction

    // Divider count width; DIV=1 still gets a (constant zero) bit
    function automatic int cnt_w(input int div);
        return (div <= 2) ? 1 : $clog2(div);
    endfunction

    // Inputs flagged as both activator and inhibitor cancel out
    function automatic int score_calc(input logic [31:0] on_v,
                                      input logic [31:0] act_v,
                                      input logic [31:0] inh_v);
        int s;
        s = 0;
        for (int i = 0; i < 32; i++) begin
            if (on_v[i] && act_v[i] && !inh_v[i]) s = s + 1;
            if (on_v[i] && inh_v[i] && !act_v[i]) s = s - 1;
        end
        return s;
    endfunction

    function automatic logic [31:0] sat_step(input logic [31:0] st,
                                             input logic [31:0] maxv,
                                             input dir_e        dir);
        logic [31:0] r;
        r = st;
        case (dir)
            DIR_UP:   if (st != maxv)  r = st + 32'd1;
            DIR_DOWN: if (st != 32'd0) r = st - 32'd1;
            default:  r = st;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/gnr_node_ecm_if.sv
// Bundle of the node's control, regulator and state-export signals.
interface gnr_node_ecm_if #(
    parameter int WIDTH      = 1,
    parameter int NUM_COPIES = 2,
    parameter int NUM_IN     = 4
);
    logic                                reset_nos;
    logic [WIDTH-1:0]                    init_state;
    logic [NUM_COPIES-1:0]               start;
    logic [NUM_IN-1:0]                   act_mask;
    logic [NUM_IN-1:0]                   inh_mask;
    logic [NUM_COPIES*NUM_IN*WIDTH-1:0]  reg_in;
    logic [NUM_COPIES*WIDTH-1:0]         state;
    logic [NUM_COPIES*WIDTH-1:0]         ecm_state;
    logic [NUM_COPIES-1:0]               upd;
    logic [NUM_COPIES-1:0]               stable;

    modport master (
        output reset_nos, init_state, start, act_mask, inh_mask, reg_in,
        input  state, ecm_state, upd, stable
    );

    modport slave (
        input  reset_nos, init_state, start, act_mask, inh_mask, reg_in,
        output state, ecm_state, upd, stable
    );
endinterface

// File: rtl/gnr_node_lane.sv
// One state copy: divider, saturating activator/inhibitor update and upd pulse.
// Settling detector built only with GNR_NODE_STABLE_DETECT_EN.
module gnr_node_lane
    import gnr_pkg::*;
#(
    parameter int WIDTH      = 1,
    parameter int NUM_IN     = 4,
    parameter int DIV        = 2,
    parameter int STABLE_LEN = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    reset_nos_i,
    input  logic [WIDTH-1:0]        init_state_i,
    input  logic                    start_i,
    input  logic [NUM_IN-1:0]       act_mask_i,
    input  logic [NUM_IN-1:0]       inh_mask_i,
    input  logic [NUM_IN*WIDTH-1:0] reg_in_i,
    output logic [WIDTH-1:0]        state_o,
    output logic                    upd_o,
    output logic                    stable_o
);
    localparam int SCORE_W = score_w(NUM_IN);
    localparam int CNT_W   = cnt_w(DIV);
    localparam logic [31:0] MAXV = (32'd1 << WIDTH) - 32'd1;

    typedef logic [CNT_W-1:0] cnt_t;

    logic [WIDTH-1:0]          state_q, state_d, next_st;
    cnt_t                      cnt_q, cnt_d;
    logic                      upd_q, upd_d;
    logic [31:0]               on_v;
    logic signed [SCORE_W-1:0] score;
    dir_e                      dir;
    logic                      do_upd;

    always_comb begin
        on_v = '0;
        for (int i = 0; i < NUM_IN; i++) on_v[i] = |reg_in_i[i*WIDTH +: WIDTH];
        score = SCORE_W'(score_calc(on_v, 32'(act_mask_i), 32'(inh_mask_i)));
        if (score == '0)             dir = DIR_HOLD;
        else if (score[SCORE_W-1])   dir = DIR_DOWN;
        else                         dir = DIR_UP;
        next_st = WIDTH'(sat_step(32'(state_q), MAXV, dir));
        do_upd  = start_i && (cnt_q == '0);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        upd_d   = 1'b0;
        if (reset_nos_i) begin
            state_d = init_state_i;
            cnt_d   = '0;
        end else if (start_i) begin
            if (do_upd) begin
                state_d = next_st;
                cnt_d   = cnt_t'(DIV - 1);
                upd_d   = 1'b1;
            end else begin
                cnt_d = cnt_q - cnt_t'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= '0;
            cnt_q   <= '0;
            upd_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            upd_q   <= upd_d;
        end
    end

    assign state_o = state_q;
    assign upd_o   = upd_q;

`ifdef GNR_NODE_STABLE_DETECT_EN
    localparam int STAB_W = $clog2(STABLE_LEN + 1);
    logic [STAB_W-1:0] stab_q, stab_d;

    // Counts consecutive updates that left the state unchanged
    always_comb begin
        stab_d = stab_q;
        if (reset_nos_i) begin
            stab_d = '0;
        end else if (do_upd) begin
            if (next_st != state_q)                   stab_d = '0;
            else if (stab_q != STAB_W'(STABLE_LEN))   stab_d = stab_q + STAB_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stab_q <= '0;
        else        stab_q <= stab_d;
    end

    assign stable_o = (stab_q == STAB_W'(STABLE_LEN));
`else
    assign stable_o = 1'b0;
`endif

endmodule

// File: rtl/gnr_node_ecm.sv
// GNR node top: NUM_COPIES independent lanes sharing masks, init value and reload.
// Optional settling detector: GNR_NODE_STABLE_DETECT_EN.
module gnr_node_ecm #(
    parameter int WIDTH      = 1,
    parameter int NUM_COPIES = 2,
    parameter int NUM_IN     = 4,
    parameter int DIV        = 2,
    parameter int STABLE_LEN = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    gnr_node_ecm_if.slave bus
);
    logic [NUM_COPIES*WIDTH-1:0] state_w;
    logic [NUM_COPIES-1:0]       upd_w;
    logic [NUM_COPIES-1:0]       stable_w;

    for (genvar k = 0; k < NUM_COPIES; k++) begin : g_lane
        gnr_node_lane #(
            .WIDTH      (WIDTH),
            .NUM_IN     (NUM_IN),
            .DIV        (DIV),
            .STABLE_LEN (STABLE_LEN)
        ) u_lane (
            .clk          (clk),
            .rst_n        (rst_n),
            .reset_nos_i  (bus.reset_nos),
            .init_state_i (bus.init_state),
            .start_i      (bus.start[k]),
            .act_mask_i   (bus.act_mask),
            .inh_mask_i   (bus.inh_mask),
            .reg_in_i     (bus.reg_in[k*NUM_IN*WIDTH +: NUM_IN*WIDTH]),
            .state_o      (state_w[k*WIDTH +: WIDTH]),
            .upd_o        (upd_w[k]),
            .stable_o     (stable_w[k])
        );
    end

    assign bus.state     = state_w;
    assign bus.ecm_state = state_w;
    assign bus.upd       = upd_w;
    assign bus.stable    = stable_w;

endmodule

// File: tb/tb_gnr_node_ecm.sv
// Self-checking bench for gnr_node_ecm: directed scenarios with literal expectations,
// then randomized traffic against a pulse-counting behavioural model.
module tb_gnr_node_ecm;
    localparam int WIDTH = 2;
    localparam int NC    = 2;
    localparam int NI    = 4;
    localparam int DIV   = 2;
    localparam int SL    = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    gnr_node_ecm_if #(.WIDTH(WIDTH), .NUM_COPIES(NC), .NUM_IN(NI)) bus ();

    gnr_node_ecm #(
        .WIDTH(WIDTH), .NUM_COPIES(NC), .NUM_IN(NI), .DIV(DIV), .STABLE_LEN(SL)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Model: state per copy, start pulses seen since last reload, last-cycle upd, unchanged run
    int m_state[NC];
    int m_pc[NC];
    int m_upd[NC];
    int m_run[NC];
    int rin[NC][NI];

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic drive_rin();
        for (int k = 0; k < NC; k++)
            for (int i = 0; i < NI; i++)
                bus.reg_in[(k*NI+i)*WIDTH +: WIDTH] = WIDTH'(rin[k][i]);
    endtask

    task automatic model_reset();
        for (int k = 0; k < NC; k++) begin
            m_state[k] = 0; m_pc[k] = 0; m_upd[k] = 0; m_run[k] = 0;
        end
    endtask

    task automatic model_edge();
        int s, ns, maxv;
        maxv = (1 << WIDTH) - 1;
        for (int k = 0; k < NC; k++) begin
            if (bus.reset_nos) begin
                m_state[k] = int'(bus.init_state);
                m_pc[k] = 0; m_upd[k] = 0; m_run[k] = 0;
            end else if (bus.start[k]) begin
                if (m_pc[k] % DIV == 0) begin
                    s = 0;
                    for (int i = 0; i < NI; i++)
                        if (rin[k][i] != 0) begin
                            if (bus.act_mask[i]) s++;
                            if (bus.inh_mask[i]) s--;
                        end
                    ns = m_state[k];
                    if (s > 0 && ns < maxv) ns++;
                    if (s < 0 && ns > 0)    ns--;
                    m_run[k]   = (ns == m_state[k]) ? ((m_run[k] < SL) ? m_run[k] + 1 : SL) : 0;
                    m_state[k] = ns;
                    m_upd[k]   = 1;
                end else begin
                    m_upd[k] = 0;
                end
                m_pc[k]++;
            end else begin
                m_upd[k] = 0;
            end
        end
    endtask

    task automatic check_all();
        int exp_stb;
        for (int k = 0; k < NC; k++) begin
`ifdef GNR_NODE_STABLE_DETECT_EN
            exp_stb = (m_run[k] == SL) ? 1 : 0;
`else
            exp_stb = 0;
`endif
            chk($sformatf("state[%0d]", k), int'(bus.state[k*WIDTH +: WIDTH]), m_state[k]);
            chk($sformatf("ecm_state[%0d]", k), int'(bus.ecm_state[k*WIDTH +: WIDTH]), m_state[k]);
            chk($sformatf("upd[%0d]", k), int'(bus.upd[k]), m_upd[k]);
            chk($sformatf("stable[%0d]", k), int'(bus.stable[k]), exp_stb);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic reload(input int v);
        bus.reset_nos = 1'b1; bus.init_state = WIDTH'(v); bus.start = '0;
        step();
        bus.reset_nos = 1'b0;
    endtask

    task automatic clear_rin();
        for (int k = 0; k < NC; k++)
            for (int i = 0; i < NI; i++) rin[k][i] = 0;
        drive_rin();
    endtask

    initial begin
        int es[5] = '{1, 1, 2, 2, 3};
        int eu[5] = '{1, 0, 1, 0, 1};

        rst_n = 1'b0;
        bus.reset_nos = 1'b0; bus.init_state = '0; bus.start = '0;
        bus.act_mask = '0; bus.inh_mask = '0;
        model_reset();
        clear_rin();
        #7;
        chk("reset state0", int'(bus.state[0 +: WIDTH]), 0);
        chk("reset upd", int'(bus.upd), 0);
        rst_n = 1'b1;

        // Some activity, then asynchronous reset mid-cycle
        bus.act_mask = 4'b0001;
        for (int k = 0; k < NC; k++) rin[k][0] = 1;
        drive_rin();
        bus.start = 2'b11;
        repeat (3) step();
        #3 rst_n = 1'b0;
        #1;
        chk("async rst state0", int'(bus.state[0 +: WIDTH]), 0);
        chk("async rst state1", int'(bus.state[WIDTH +: WIDTH]), 0);
        chk("async rst upd", int'(bus.upd), 0);
        model_reset();
        bus.start = '0;
        #1 rst_n = 1'b1;

        reload(2);
        chk("reload copy0", int'(bus.state[0 +: WIDTH]), 2);
        chk("reload copy1", int'(bus.state[WIDTH +: WIDTH]), 2);

        // Divider: updates on pulses 1, 3, 5
        clear_rin();
        reload(0);
        bus.act_mask = 4'b0001; bus.inh_mask = 4'b0000;
        rin[0][0] = 1; drive_rin();
        bus.start = 2'b01;
        for (int p = 0; p < 5; p++) begin
            step();
            chk($sformatf("div state p%0d", p+1), int'(bus.state[0 +: WIDTH]), es[p]);
            chk($sformatf("div upd p%0d", p+1), int'(bus.upd[0]), eu[p]);
        end

        // Saturation at both ends
        reload(3);
        bus.start = 2'b01; step();
        chk("sat hi state", int'(bus.state[0 +: WIDTH]), 3);
        chk("sat hi upd", int'(bus.upd[0]), 1);
        reload(0);
        bus.act_mask = 4'b0000; bus.inh_mask = 4'b0001;
        bus.start = 2'b01; step();
        chk("sat lo state", int'(bus.state[0 +: WIDTH]), 0);
        chk("sat lo upd", int'(bus.upd[0]), 1);

        // Balance and overlap
        reload(1);
        bus.act_mask = 4'b0001; bus.inh_mask = 4'b0010;
        rin[0][1] = 1; drive_rin();
        bus.start = 2'b01; step();
        chk("balance state", int'(bus.state[0 +: WIDTH]), 1);
        reload(1);
        bus.inh_mask = 4'b0001;
        rin[0][1] = 0; drive_rin();
        bus.start = 2'b01; step();
        chk("overlap state", int'(bus.state[0 +: WIDTH]), 1);
        chk("overlap upd", int'(bus.upd[0]), 1);

        // reset_nos wins over start; counter restarts at zero
        bus.inh_mask = 4'b0000;
        rin[1][0] = 1; drive_rin();
        bus.reset_nos = 1'b1; bus.init_state = 2'd2; bus.start = 2'b10;
        step();
        bus.reset_nos = 1'b0;
        chk("prio state1", int'(bus.state[WIDTH +: WIDTH]), 2);
        chk("prio upd1", int'(bus.upd[1]), 0);
        step();
        chk("prio next upd1", int'(bus.upd[1]), 1);
        chk("prio next state1", int'(bus.state[WIDTH +: WIDTH]), 3);
        bus.start = 2'b01; step();
        chk("indep state1", int'(bus.state[WIDTH +: WIDTH]), 3);
        chk("indep upd1", int'(bus.upd[1]), 0);

`ifdef GNR_NODE_STABLE_DETECT_EN
        clear_rin();
        reload(1);
        bus.act_mask = 4'b0000; bus.inh_mask = 4'b0000;
        bus.start = 2'b01;
        repeat (6) step();
        chk("stable before 4th", int'(bus.stable[0]), 0);
        step();
        chk("stable after 4th", int'(bus.stable[0]), 1);
        bus.act_mask = 4'b0001; rin[0][0] = 1; drive_rin();
        step();
        chk("stable hold", int'(bus.stable[0]), 1);
        step();
        chk("stable falls", int'(bus.stable[0]), 0);
        chk("stable change state", int'(bus.state[0 +: WIDTH]), 2);
`endif

        // Randomized traffic
        bus.start = '0;
        for (int c = 0; c < 400; c++) begin
            bus.reset_nos  = ($urandom_range(0, 19) == 0);
            bus.init_state = WIDTH'($urandom);
            bus.start      = NC'($urandom);
            if (c % 16 == 0) begin
                bus.act_mask = NI'($urandom);
                bus.inh_mask = NI'($urandom);
            end
            for (int k = 0; k < NC; k++)
                for (int i = 0; i < NI; i++)
                    rin[k][i] = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(0, (1 << WIDTH) - 1));
            drive_rin();
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
